// File: rtl/dcache_flush_seq.sv
// Whole-cache flush/invalidate walker for the dcache tag array.
// Visits every (index, way), writes back dirty lines, then clears them.

package config_pkg;

   typedef struct packed {
      int unsigned DcacheByteSize;
      int unsigned DcacheSetAssoc;
      int unsigned DcacheLineWidth;
      int unsigned PLEN;
   } cva6_user_cfg_t;

   typedef struct packed {
      int unsigned DCACHE_SET_ASSOC;
      int unsigned DCACHE_SET_ASSOC_WIDTH;
      int unsigned DCACHE_INDEX_WIDTH;
      int unsigned DCACHE_OFFSET_WIDTH;
      int unsigned DCACHE_TAG_WIDTH;
      int unsigned DCACHE_NUM_WORDS;
      int unsigned PLEN;
   } cva6_cfg_t;

endpackage

package cva6_config_pkg;

   localparam config_pkg::cva6_user_cfg_t cva6_cfg = '{
      DcacheByteSize:  4096,
      DcacheSetAssoc:  2,
      DcacheLineWidth: 128,
      PLEN:            56
   };

endpackage

package build_config_pkg;

   function automatic config_pkg::cva6_cfg_t build_config(
      input config_pkg::cva6_user_cfg_t u
   );
      config_pkg::cva6_cfg_t c;
      c.DCACHE_SET_ASSOC = u.DcacheSetAssoc;
      // A direct-mapped cache still gets a 1-bit way field.
      c.DCACHE_SET_ASSOC_WIDTH = (u.DcacheSetAssoc > 1)
                               ? $clog2(u.DcacheSetAssoc) : 1;
      c.DCACHE_INDEX_WIDTH =
         $clog2(u.DcacheByteSize / u.DcacheSetAssoc);
      c.DCACHE_OFFSET_WIDTH = $clog2(u.DcacheLineWidth / 8);
      c.DCACHE_TAG_WIDTH = u.PLEN - c.DCACHE_INDEX_WIDTH;
      c.DCACHE_NUM_WORDS =
         2 ** (c.DCACHE_INDEX_WIDTH - c.DCACHE_OFFSET_WIDTH);
      c.PLEN = u.PLEN;
      return c;
   endfunction

endpackage

module dcache_flush_seq #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg =
      build_config_pkg::build_config(cva6_config_pkg::cva6_cfg),
   localparam int unsigned IDX_W =
      CVA6Cfg.DCACHE_INDEX_WIDTH - CVA6Cfg.DCACHE_OFFSET_WIDTH,
   localparam int unsigned WAY_W = CVA6Cfg.DCACHE_SET_ASSOC_WIDTH,
   localparam int unsigned CNT_W = IDX_W + WAY_W + 1,
   localparam int unsigned TAG_W = CVA6Cfg.DCACHE_TAG_WIDTH,
   localparam int unsigned PLEN  = CVA6Cfg.PLEN
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             inv_only_i,
   output logic             flush_ack_o,
   output logic             busy_o,
   output logic             tag_req_o,
   input  logic             tag_gnt_i,
   output logic [IDX_W-1:0] tag_index_o,
   output logic [WAY_W-1:0] tag_way_o,
   input  logic             tag_rvalid_i,
   input  logic             tag_valid_i,
   input  logic             tag_dirty_i,
   input  logic [TAG_W-1:0] tag_rdata_i,
   output logic             wb_req_o,
   input  logic             wb_gnt_i,
   output logic [PLEN-1:0]  wb_addr_o,
   input  logic             wb_done_i,
   output logic             inv_req_o,
   input  logic             inv_gnt_i,
   output logic [CNT_W-1:0] wb_cnt_o
);

   localparam int unsigned OFF_W  = CVA6Cfg.DCACHE_OFFSET_WIDTH;
   localparam int unsigned NWAYS  = CVA6Cfg.DCACHE_SET_ASSOC;
   localparam int unsigned NSETS  = CVA6Cfg.DCACHE_NUM_WORDS;
   localparam int unsigned FULL_W = TAG_W + IDX_W + OFF_W;
   localparam int unsigned ADDR_W = (FULL_W > PLEN) ? FULL_W : PLEN;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NWAYS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_WB      = 3'd3;
   localparam logic [2:0] S_WB_WAIT = 3'd4;
   localparam logic [2:0] S_INV     = 3'd5;
   localparam logic [2:0] S_NEXT    = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic             inv_only_q, inv_only_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

   logic             way_last;
   logic             idx_last;
   logic             cnt_sat;
   logic [ADDR_W-1:0] addr_full;

   assign way_last = (way_q == LAST_WAY);
   assign idx_last = (index_q == LAST_IDX);
   assign cnt_sat  = &wb_cnt_q;

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      way_d      = way_q;
      inv_only_d = inv_only_q;
      tag_d      = tag_q;
      wb_cnt_d   = wb_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (flush_i) begin
               inv_only_d = inv_only_i;
               index_d    = '0;
               way_d      = '0;
               wb_cnt_d   = '0;
               state_d    = S_RD;
            end
         end
         S_RD: begin
            if (tag_gnt_i) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (tag_rvalid_i) begin
               tag_d = tag_rdata_i;
               if (!tag_valid_i)
                  state_d = S_NEXT;
               else if (tag_dirty_i && !inv_only_q)
                  state_d = S_WB;
               else
                  state_d = S_INV;
            end
         end
         S_WB: begin
            if (wb_gnt_i) begin
               if (!cnt_sat) wb_cnt_d = wb_cnt_q + 1'b1;
               state_d = S_WB_WAIT;
            end
         end
         S_WB_WAIT: begin
            if (wb_done_i) state_d = S_INV;
         end
         S_INV: begin
            if (inv_gnt_i) state_d = S_NEXT;
         end
         S_NEXT: begin
            // Index-outer, way-inner walk order.
            if (way_last) begin
               way_d   = '0;
               index_d = index_q + 1'b1;
            end else begin
               way_d = way_q + 1'b1;
            end
            state_d = (way_last && idx_last) ? S_DONE : S_RD;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         index_q    <= '0;
         way_q      <= '0;
         inv_only_q <= 1'b0;
         tag_q      <= '0;
         wb_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         way_q      <= way_d;
         inv_only_q <= inv_only_d;
         tag_q      <= tag_d;
         wb_cnt_q   <= wb_cnt_d;
      end
   end

   // Line address: tag above index, offset bits zeroed.
   assign addr_full = ADDR_W'({tag_q, index_q, {OFF_W{1'b0}}});

   assign wb_addr_o   = addr_full[PLEN-1:0];
   assign tag_index_o = index_q;
   assign tag_way_o   = way_q;
   assign wb_cnt_o    = wb_cnt_q;
   assign busy_o      = (state_q != S_IDLE);
   assign flush_ack_o = (state_q == S_DONE);
   assign tag_req_o   = (state_q == S_RD);
   assign wb_req_o    = (state_q == S_WB);
   assign inv_req_o   = (state_q == S_INV);

endmodule

// File: tb/tb_dcache_flush_seq.sv
// Directed bench for dcache_flush_seq: vector table plus
// hand-written reset, stall and back-to-back flush sequences.

module tb_dcache_flush_seq;

   localparam int IDX_W = 7;
   localparam int WAY_W = 1;
   localparam int CNT_W = 9;
   localparam int TAG_W = 45;
   localparam int PLEN  = 56;
   localparam int NSETS = 128;
   localparam int NWAYS = 2;

   logic             clk;
   logic             rst_ni;
   logic             flush_i;
   logic             inv_only_i;
   logic             flush_ack_o;
   logic             busy_o;
   logic             tag_req_o;
   logic             tag_gnt_i;
   logic [IDX_W-1:0] tag_index_o;
   logic [WAY_W-1:0] tag_way_o;
   logic             tag_rvalid_i;
   logic             tag_valid_i;
   logic             tag_dirty_i;
   logic [TAG_W-1:0] tag_rdata_i;
   logic             wb_req_o;
   logic             wb_gnt_i;
   logic [PLEN-1:0]  wb_addr_o;
   logic             wb_done_i;
   logic             inv_req_o;
   logic             inv_gnt_i;
   logic [CNT_W-1:0] wb_cnt_o;

   dcache_flush_seq dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .inv_only_i   (inv_only_i),
      .flush_ack_o  (flush_ack_o),
      .busy_o       (busy_o),
      .tag_req_o    (tag_req_o),
      .tag_gnt_i    (tag_gnt_i),
      .tag_index_o  (tag_index_o),
      .tag_way_o    (tag_way_o),
      .tag_rvalid_i (tag_rvalid_i),
      .tag_valid_i  (tag_valid_i),
      .tag_dirty_i  (tag_dirty_i),
      .tag_rdata_i  (tag_rdata_i),
      .wb_req_o     (wb_req_o),
      .wb_gnt_i     (wb_gnt_i),
      .wb_addr_o    (wb_addr_o),
      .wb_done_i    (wb_done_i),
      .inv_req_o    (inv_req_o),
      .inv_gnt_i    (inv_gnt_i),
      .wb_cnt_o     (wb_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Tag array model and observation logs.
   bit               mv [NSETS][NWAYS];
   bit               md [NSETS][NWAYS];
   logic [TAG_W-1:0] mt [NSETS][NWAYS];
   int               rc [NSETS][NWAYS];
   logic [PLEN-1:0]  wb_q[$];
   int               inv_i_q[$];
   int               inv_w_q[$];
   int               ack_cnt = 0;
   int               stab_err = 0;
   bit               stall_en = 0;

   typedef struct {
      int               idx;
      int               way;
      logic [TAG_W-1:0] tag;
      bit               v;
      bit               d;
      bit               inv;
      int               exp_wb;
      logic [PLEN-1:0]  exp_addr;
      int               exp_inv;
      int               exp_cyc;
   } vec_t;

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, got, exp);
      end
   endtask

   function automatic int stall(input int mx);
      if (!stall_en) return 0;
      return int'($urandom_range(0, mx));
   endfunction

   function automatic int rd_bad();
      int n = 0;
      for (int i = 0; i < NSETS; i++)
         for (int w = 0; w < NWAYS; w++)
            if (rc[i][w] != 1) n++;
      return n;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NSETS; i++)
         for (int w = 0; w < NWAYS; w++) begin
            mv[i][w] = 0;
            md[i][w] = 0;
            mt[i][w] = '0;
            rc[i][w] = 0;
         end
      wb_q.delete();
      inv_i_q.delete();
      inv_w_q.delete();
      ack_cnt = 0;
      stab_err = 0;
   endtask

   // Memory-side responder: grants, read data, writeback done.
   int               tst, wst, ist, rvd, wd;
   int               rd_i, rd_w;
   bit               pend_rd, pend_wb;
   bit               ht, hw, hi;
   logic [IDX_W-1:0] t_idx, i_idx;
   logic [WAY_W-1:0] t_way, i_way;
   logic [PLEN-1:0]  w_addr;

   initial begin
      tag_gnt_i = 0; tag_rvalid_i = 0; tag_valid_i = 0;
      tag_dirty_i = 0; tag_rdata_i = '0;
      wb_gnt_i = 0; wb_done_i = 0; inv_gnt_i = 0;
      pend_rd = 0; pend_wb = 0; tst = 0; wst = 0; ist = 0;
      rvd = 0; wd = 0; ht = 0; hw = 0; hi = 0;
      forever begin
         @(negedge clk);
         tag_gnt_i = 0; tag_rvalid_i = 0; tag_valid_i = 0;
         tag_dirty_i = 0; tag_rdata_i = '0;
         wb_gnt_i = 0; wb_done_i = 0; inv_gnt_i = 0;
         if (!rst_ni) begin
            pend_rd = 0; pend_wb = 0;
            tst = 0; wst = 0; ist = 0;
            ht = 0; hw = 0; hi = 0;
         end else begin
            if (flush_ack_o) ack_cnt++;
            if (tag_req_o) begin
               if (ht && (tag_index_o !== t_idx ||
                          tag_way_o !== t_way)) stab_err++;
               ht = 1; t_idx = tag_index_o; t_way = tag_way_o;
               if (tst == 0) begin
                  tag_gnt_i = 1;
                  pend_rd = 1;
                  rd_i = int'(tag_index_o);
                  rd_w = int'(tag_way_o);
                  rvd = stall(3);
                  tst = stall(5);
                  ht = 0;
               end else begin
                  tst--;
                  // Stray response while still in RD; must be ignored.
                  tag_rvalid_i = 1; tag_valid_i = 1;
                  tag_dirty_i = 1; tag_rdata_i = '1;
               end
            end else begin
               ht = 0;
               if (pend_rd) begin
                  if (rvd == 0) begin
                     tag_rvalid_i = 1;
                     tag_valid_i = mv[rd_i][rd_w];
                     tag_dirty_i = md[rd_i][rd_w];
                     tag_rdata_i = mt[rd_i][rd_w];
                     rc[rd_i][rd_w]++;
                     pend_rd = 0;
                  end else rvd--;
               end
            end
            if (wb_req_o) begin
               if (hw && wb_addr_o !== w_addr) stab_err++;
               hw = 1; w_addr = wb_addr_o;
               if (wst == 0) begin
                  wb_gnt_i = 1;
                  wb_q.push_back(wb_addr_o);
                  pend_wb = 1;
                  wd = stall(5);
                  wst = stall(5);
                  hw = 0;
               end else wst--;
            end else begin
               hw = 0;
               if (pend_wb) begin
                  if (wd == 0) begin
                     wb_done_i = 1;
                     pend_wb = 0;
                  end else wd--;
               end
            end
            if (inv_req_o) begin
               if (hi && (tag_index_o !== i_idx ||
                          tag_way_o !== i_way)) stab_err++;
               hi = 1; i_idx = tag_index_o; i_way = tag_way_o;
               if (ist == 0) begin
                  inv_gnt_i = 1;
                  inv_i_q.push_back(int'(tag_index_o));
                  inv_w_q.push_back(int'(tag_way_o));
                  mv[tag_index_o][tag_way_o] = 0;
                  md[tag_index_o][tag_way_o] = 0;
                  ist = stall(5);
                  hi = 0;
               end else ist--;
            end else hi = 0;
         end
      end
   end

   task automatic wait_ack(output bit ok, output int at);
      ok = 0;
      at = 0;
      for (int k = 0; k < 20000; k++) begin
         if (flush_ack_o) begin
            ok = 1;
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_line(input int i, input int w,
                            output bit ok);
      ok = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (tag_req_o && tag_index_o == IDX_W'(i) &&
             tag_way_o == WAY_W'(w)) begin
            ok = 1;
            break;
         end
      end
   endtask

   // Cycle count spans the IDLE sampling cycle through the ack cycle.
   task automatic run_flush(input bit inv, output int ncyc,
                            output bit ok);
      int c0;
      int at;
      @(negedge clk);
      flush_i = 1;
      inv_only_i = inv;
      @(negedge clk);
      c0 = cyc;
      flush_i = 0;
      inv_only_i = 0;
      wait_ack(ok, at);
      ncyc = at - c0 + 2;
   endtask

   vec_t             vt[7];
   logic [PLEN-1:0]  exp_q[$];
   int               dpi[10];
   int               dpw[10];
   int               ncyc;
   int               at;
   int               nval;
   bit               ok;
   logic [CNT_W-1:0] cnt_ack;

   initial begin
      vt[0] = '{idx:0, way:0, tag:'0, v:0, d:0, inv:0,
                exp_wb:0, exp_addr:'0, exp_inv:0, exp_cyc:770};
      vt[1] = '{idx:5, way:1, tag:45'h1234, v:1, d:1, inv:0,
                exp_wb:1, exp_addr:56'h91A050, exp_inv:1,
                exp_cyc:773};
      vt[2] = '{idx:5, way:1, tag:45'h1234, v:1, d:1, inv:1,
                exp_wb:0, exp_addr:'0, exp_inv:1, exp_cyc:771};
      vt[3] = '{idx:127, way:0, tag:45'h1ABC, v:1, d:0, inv:0,
                exp_wb:0, exp_addr:'0, exp_inv:1, exp_cyc:771};
      vt[4] = '{idx:0, way:0, tag:45'h1, v:1, d:1, inv:0,
                exp_wb:1, exp_addr:56'h800, exp_inv:1,
                exp_cyc:773};
      vt[5] = '{idx:127, way:1, tag:{TAG_W{1'b1}}, v:1, d:1,
                inv:0, exp_wb:1, exp_addr:56'hFFFFFFFFFFFFF0,
                exp_inv:1, exp_cyc:773};
      vt[6] = '{idx:3, way:0, tag:45'h55, v:0, d:1, inv:0,
                exp_wb:0, exp_addr:'0, exp_inv:0, exp_cyc:770};
      dpi = '{0, 0, 5, 17, 40, 63, 64, 100, 126, 127};
      dpw = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1};

      rst_ni = 0;
      flush_i = 0;
      inv_only_i = 0;
      clear_model();
      #3;
      check("reset ctl", {busy_o, tag_req_o, wb_req_o,
                          inv_req_o, flush_ack_o}, 0);
      check("reset cnt", wb_cnt_o, 0);
      repeat (2) @(negedge clk);
      rst_ni = 1;

      for (int v = 0; v < 7; v++) begin
         clear_model();
         mv[vt[v].idx][vt[v].way] = vt[v].v;
         md[vt[v].idx][vt[v].way] = vt[v].d;
         mt[vt[v].idx][vt[v].way] = vt[v].tag;
         run_flush(vt[v].inv, ncyc, ok);
         check($sformatf("v%0d ack", v), ok, 1);
         check($sformatf("v%0d cycles", v), ncyc, vt[v].exp_cyc);
         check($sformatf("v%0d wb_cnt", v), wb_cnt_o,
               vt[v].exp_wb);
         check($sformatf("v%0d n_wb", v), wb_q.size(),
               vt[v].exp_wb);
         if (wb_q.size() > 0)
            check($sformatf("v%0d wb_addr", v), wb_q[0],
                  vt[v].exp_addr);
         check($sformatf("v%0d n_inv", v), inv_i_q.size(),
               vt[v].exp_inv);
         if (inv_i_q.size() > 0)
            check($sformatf("v%0d inv_line", v),
                  {inv_i_q[0], inv_w_q[0]},
                  {vt[v].idx, vt[v].way});
         cnt_ack = wb_cnt_o;
         repeat (3) @(negedge clk);
         check($sformatf("v%0d cnt_hold", v), wb_cnt_o, cnt_ack);
         check($sformatf("v%0d ack_pulses", v), ack_cnt, 1);
         check($sformatf("v%0d idle", v), busy_o, 0);
         check($sformatf("v%0d reads", v), rd_bad(), 0);
      end

      // Random stalls, ten dirty lines plus clean and invalid ones.
      clear_model();
      stall_en = 1;
      for (int k = 0; k < 10; k++) begin
         mv[dpi[k]][dpw[k]] = 1;
         md[dpi[k]][dpw[k]] = 1;
         mt[dpi[k]][dpw[k]] = TAG_W'({$urandom, $urandom});
      end
      mv[2][0] = 1;  mt[2][0] = 45'h777;
      mv[90][1] = 1; mt[90][1] = 45'h999;
      md[50][0] = 1; mt[50][0] = 45'h333;
      exp_q.delete();
      for (int i = 0; i < NSETS; i++)
         for (int w = 0; w < NWAYS; w++)
            if (mv[i][w] && md[i][w])
               exp_q.push_back({mt[i][w], IDX_W'(i), 4'h0});
      run_flush(1'b0, ncyc, ok);
      check("stall ack", ok, 1);
      check("stall n_wb", wb_q.size(), 10);
      for (int k = 0; k < 10; k++)
         if (k < wb_q.size())
            check($sformatf("stall wb%0d", k), wb_q[k], exp_q[k]);
      check("stall wb_cnt", wb_cnt_o, 10);
      check("stall n_inv", inv_i_q.size(), 12);
      repeat (3) @(negedge clk);
      nval = 0;
      for (int i = 0; i < NSETS; i++)
         for (int w = 0; w < NWAYS; w++)
            if (mv[i][w]) nval++;
      check("stall left_valid", nval, 0);
      check("stall stable", stab_err, 0);
      check("stall reads", rd_bad(), 0);
      check("stall ack_pulses", ack_cnt, 1);
      stall_en = 0;

      // Asynchronous reset while reading line 40.
      clear_model();
      mv[3][1] = 1; md[3][1] = 1; mt[3][1] = 45'hABC;
      @(negedge clk);
      flush_i = 1;
      @(negedge clk);
      flush_i = 0;
      wait_line(20, 0, ok);
      check("rst line40", ok, 1);
      check("rst pre cnt", wb_cnt_o, 1);
      #2 rst_ni = 0;
      #1;
      check("rst ctl", {busy_o, tag_req_o, wb_req_o,
                        inv_req_o, flush_ack_o}, 0);
      check("rst cnt", wb_cnt_o, 0);
      check("rst line", {tag_index_o, tag_way_o}, 0);
      check("rst addr", wb_addr_o, 0);
      repeat (2) @(negedge clk);
      rst_ni = 1;
      @(negedge clk);
      for (int i = 0; i < NSETS; i++)
         for (int w = 0; w < NWAYS; w++) rc[i][w] = 0;
      ack_cnt = 0;
      flush_i = 1;
      @(negedge clk);
      flush_i = 0;
      check("restart first", {tag_req_o, tag_index_o, tag_way_o},
            {1'b1, 8'h00});
      wait_ack(ok, at);
      check("restart ack", ok, 1);
      repeat (2) @(negedge clk);
      check("restart reads", rd_bad(), 0);

      // flush_i held across the ack, then dropped at line 3.
      clear_model();
      mv[0][1] = 1; md[0][1] = 1; mt[0][1] = 45'h42;
      @(negedge clk);
      flush_i = 1;
      @(negedge clk);
      wait_ack(ok, at);
      check("hold ack1", ok, 1);
      check("hold cnt1", wb_cnt_o, 1);
      @(negedge clk);
      check("hold idle", {busy_o, tag_req_o}, 0);
      @(negedge clk);
      check("hold restart",
            {busy_o, tag_req_o, tag_index_o, tag_way_o},
            {2'b11, 8'h00});
      wait_line(1, 1, ok);
      check("hold line3", ok, 1);
      flush_i = 0;
      wait_ack(ok, at);
      check("hold ack2", ok, 1);
      check("hold cnt2", wb_cnt_o, 0);
      repeat (5) @(negedge clk);
      check("hold stop", busy_o, 0);
      check("hold pulses", ack_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
